// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: operation codes, FSM state
// codes and a small index helper used by the round-robin pointer.
package logic_unit_arbiter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND  = 2'b00;
    localparam op_t OP_OR   = 2'b01;
    localparam op_t OP_XOR  = 2'b10;
    localparam op_t OP_NAND = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Index following idx, wrapping to 0 after last_idx.
    function automatic logic [2:0] next_index(input logic [2:0] idx, input logic [2:0] last_idx);
        logic [2:0] nxt;
        if (idx == last_idx) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Command/response bundle between the requesters and the logic-unit arbiter.
// master = requester side, slave = arbiter side.
interface logic_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [2:0]               grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, grant_id, busy
    );
endinterface

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational bitwise logic unit: AND / OR / XOR / NAND, no carries or flags.
module logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise function named by op.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit among NUM_REQ requesters.
// One transaction at a time: IDLE (accept) -> EXEC (compute) -> RESP (return).
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input logic                 clk,
    input logic                 rst,
    logic_unit_arbiter_if.slave bus
);

    localparam logic [2:0]         LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         state_r;
    logic [2:0]         ptr_r;
    logic [2:0]         grant_r;
    op_t                op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   rsp_data_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic               busy_r;

    logic               hi_found_s;
    logic               lo_found_s;
    logic [2:0]         hi_idx_s;
    logic [2:0]         lo_idx_s;
    logic               win_found_s;
    logic [2:0]         win_idx_s;
    op_t                sel_op_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [WIDTH-1:0]   lu_y_s;
    logic               rsp_hs_s;

    // Round-robin search: lowest valid index at/after the pointer, else lowest valid below it.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = 3'd0;
        lo_idx_s   = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i >= int'(ptr_r))) begin
                hi_found_s = 1'b1;
                hi_idx_s   = 3'(i);
            end else if (bus.req_valid[i]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = 3'(i);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        win_found_s = hi_found_s | lo_found_s;
        win_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Pick the winner's command fields out of the packed request buses.
    always_comb begin
        sel_op_s = OP_AND;
        sel_a_s  = {WIDTH{1'b0}};
        sel_b_s  = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == 3'(i)) begin
                sel_op_s = bus.req_op[2*i +: 2];
                sel_a_s  = bus.req_a[WIDTH*i +: WIDTH];
                sel_b_s  = bus.req_b[WIDTH*i +: WIDTH];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // Accept strobe: only in IDLE, only for the winner, suppressed while reset is held.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if (!rst && (state_r == ST_IDLE) && win_found_s) begin
            req_ready_s = ONE_HOT_0 << win_idx_s;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Only the granted requester's rsp_ready can complete the response.
    assign rsp_hs_s = |(bus.rsp_ready & rsp_valid_r);

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .y  (lu_y_s)
    );

    // Transaction FSM with operand latch, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            grant_r     <= 3'd0;
            op_r        <= OP_AND;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        op_r    <= sel_op_s;
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        grant_r <= win_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_data_r  <= lu_y_s;
                    rsp_valid_r <= ONE_HOT_0 << grant_r;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= {NUM_REQ{1'b0}};
                        ptr_r       <= next_index(grant_r, LAST_IDX);
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= {NUM_REQ{1'b0}};
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.grant_id  = grant_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table, directed corner
// sequences and randomized transactions against a transaction-level model.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_g = N - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_unit_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  ops;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_g;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first valid requester strictly after the last one served, circularly.
    function automatic int pick(input logic [3:0] valid, input int last);
        for (int k = 1; k <= N; k++) begin
            if (valid[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.rsp_ready = 4'hF;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        bus.req_valid = 4'h0;
        bus.rsp_ready = 4'h0;
        last_g = N - 1;
    endtask

    // One arbitration round starting in IDLE; checks accept, exec, response and release.
    task automatic run_txn(input logic [3:0] valid, input logic [7:0] ops, input logic [31:0] a,
                           input logic [31:0] b, input int exp_g, input logic [7:0] exp_d,
                           input int hold, input logic [3:0] noise, input logic [3:0] busy_valid);
        logic [3:0] oh;
        bus.req_valid = valid;
        bus.req_op    = ops;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = noise;
        #1;
        if (exp_g < 0) begin
            check("idle_req_ready", bus.req_ready, 0);
            check("idle_busy", bus.busy, 0);
            tick();
            return;
        end
        oh = 4'b0001 << exp_g;
        check("accept_req_ready", bus.req_ready, oh);
        check("accept_busy", bus.busy, 0);
        check("accept_rsp_valid", bus.rsp_valid, 0);
        tick();
        bus.req_valid = busy_valid;
        bus.req_op    = 8'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.rsp_ready = noise & ~oh;
        #1;
        check("exec_req_ready", bus.req_ready, 0);
        check("exec_busy", bus.busy, 1);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        check("exec_grant_id", bus.grant_id, exp_g);
        tick();
        for (int d = 0; d <= hold; d++) begin
            bus.rsp_ready = (d == hold) ? (noise | oh) : (noise & ~oh);
            #1;
            check("resp_rsp_valid", bus.rsp_valid, oh);
            check("resp_rsp_data", bus.rsp_data, exp_d);
            check("resp_busy", bus.busy, 1);
            check("resp_req_ready", bus.req_ready, 0);
            check("resp_grant_id", bus.grant_id, exp_g);
            tick();
        end
        bus.req_valid = 4'h0;
        bus.rsp_ready = 4'h0;
        #1;
        check("done_rsp_valid", bus.rsp_valid, 0);
        check("done_rsp_data", bus.rsp_data, exp_d);
        check("done_busy", bus.busy, 0);
        last_g = exp_g;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [3:0]  rv;
        logic [7:0]  rops;
        logic [31:0] ra;
        logic [31:0] rb;
        int          g;
        logic [7:0]  d;

        vecs[0] = '{4'b0001, 8'h00, 32'h5566_77F0, 32'h1122_333C, 0, 8'h30};
        vecs[1] = '{4'b1111, 8'h39, 32'h00FF_AA0F, 32'hFFFF_FFF0, 0, 8'hFF};
        vecs[2] = '{4'b1111, 8'h39, 32'h00FF_AA0F, 32'hFFFF_FFF0, 1, 8'h55};
        vecs[3] = '{4'b1111, 8'h39, 32'h00FF_AA0F, 32'hFFFF_FFF0, 2, 8'h00};
        vecs[4] = '{4'b1111, 8'h39, 32'h00FF_AA0F, 32'hFFFF_FFF0, 3, 8'h00};

        rst = 1'b1;
        bus.req_valid = 4'h0;
        bus.req_op    = 8'h00;
        bus.req_a     = 32'h0;
        bus.req_b     = 32'h0;
        bus.rsp_ready = 4'h0;

        // Reset with every requester asking.
        do_reset();

        // Single AND from requester 0.
        run_txn(vecs[0].valid, vecs[0].ops, vecs[0].a, vecs[0].b, vecs[0].exp_g, vecs[0].exp_d,
                0, 4'h0, 4'h0);

        // All four continuously valid: back-to-back round robin, 3 cycles each.
        do_reset();
        c0 = cyc;
        for (int i = 1; i < 5; i++) begin
            run_txn(vecs[i].valid, vecs[i].ops, vecs[i].a, vecs[i].b, vecs[i].exp_g, vecs[i].exp_d,
                    0, 4'hF, 4'hF);
        end
        check("rr_cycles", cyc - c0, 12);

        // Requester 1 stalls its response for 5 cycles while requester 0 waits.
        run_txn(4'b0010, 8'h04, 32'h0000_1200, 32'h0000_2100, 1, 8'h33, 5, 4'b1101, 4'b0001);
        run_txn(4'b0001, 8'h02, 32'h0000_005A, 32'h0000_00FF, 0, 8'hA5, 0, 4'h0, 4'h0);

        // Reset during EXEC abandons the transaction.
        bus.req_valid = 4'b0100;
        bus.req_op    = 8'h30;
        #1;
        check("abort_accept", bus.req_ready, 4'b0100);
        tick();
        rst = 1'b1;
        bus.req_valid = 4'h0;
        bus.rsp_ready = 4'hF;
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_grant_id", bus.grant_id, 0);
        check("abort_rsp_data", bus.rsp_data, 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_rsp_valid", bus.rsp_valid, 0);
            tick();
        end
        bus.rsp_ready = 4'h0;
        last_g = N - 1;
        run_txn(4'b1010, 8'h00, 32'h0000_C300, 32'h0000_F000, 1, 8'hC0, 1, 4'h0, 4'h0);

        // Requesters 0 and 2 always valid: they must alternate.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            rops = 8'($urandom);
            ra   = $urandom;
            rb   = $urandom;
            g    = (j % 2 == 0) ? 0 : 2;
            run_txn(4'b0101, rops, ra, rb, g, alu(rops[2*g +: 2], ra[8*g +: 8], rb[8*g +: 8]),
                    j % 2, 4'h0, 4'b0101);
        end

        // Randomized transactions against the model.
        for (int j = 0; j < 60; j++) begin
            rv   = 4'($urandom_range(0, 15));
            rops = 8'($urandom);
            ra   = $urandom;
            rb   = $urandom;
            g    = pick(rv, last_g);
            d    = (g >= 0) ? alu(rops[2*g +: 2], ra[8*g +: 8], rb[8*g +: 8]) : 8'h00;
            run_txn(rv, rops, ra, rb, g, d, $urandom_range(0, 3), 4'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
